load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, max bus wait cycles before abort (legal range 1..255).
REQ-002 Port list (name direction width meaning); one clock; reset is synchronous and active-low:
  clk  input  1  rising-edge clock
  rst_n  input  1  synchronous active-low reset
  mem_read  input  1  load request from controller
  mem_write  input  1  store request from controller
  data_mem_mode  input  3  access size/sign, DM_* code (equal to instruction funct3)
  addr  input  32  byte address (ALU result)
  store_data  input  32  rs2 value
  load_data  output  32  extended load result
  stall  output  1  hold PC/instruction while access pending
  misaligned  output  1  misaligned access flag
  timeout_err  output  1  bus timeout pulse
  bus_req  output  1  bus request
  bus_we  output  1  1 = write
  bus_addr  output  32  word address {addr[31:2],2'b00}
  bus_wstrb  output  4  byte write strobes
  bus_wdata  output  32  lane-replicated write data
  bus_ack  input  1  bus completion
  bus_rdata  input  32  bus read word

Function
REQ-003 The block SHALL implement FSM states IDLE, REQ, DONE.
REQ-004 IDLE: if mem_write|mem_read and aligned, the block SHALL latch addr, mode, we, strobes, wdata and go to REQ next cycle; mem_write SHALL have priority when both are high.
REQ-005 REQ: bus_req=1 with all bus_* outputs stable until bus_ack is sampled high, then the block SHALL go to DONE; an ack in the first REQ cycle SHALL be accepted (minimum 2-cycle access IDLE->REQ->DONE).
REQ-006 DONE: bus_req=0, stall=0 for exactly one cycle, unconditional return to IDLE.
REQ-007 stall SHALL be combinational: (mem_read|mem_write) & state!=DONE & ~misaligned.
REQ-008 Alignment: LH/LHU/SH misaligned if addr[0]=1; LW/SW misaligned if addr[1:0]!=0; byte accesses never misaligned.
REQ-009 Misaligned request in IDLE: no bus transaction, misaligned=1 combinationally, stall=0, load_data unchanged.
REQ-010 Store strobes: SB 4'b0001<<addr[1:0], wdata {4{store_data[7:0]}}; SH 4'b0011<<{addr[1],1'b0}, wdata {2{store_data[15:0]}}; SW 4'b1111, wdata store_data; other store codes SHALL act as SW.
REQ-011 Loads: bus_we=0, bus_wstrb=4'b0000.
REQ-012 Load data SHALL be captured on the edge where bus_ack=1 in REQ: byte lane addr[1:0], halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; other load codes SHALL act as LW.
REQ-013 load_data SHALL hold until the next completed load, timeout, or reset; store completion SHALL NOT change it.
REQ-014 An 8-bit wait counter SHALL clear on REQ entry and increment each REQ cycle without ack; on reaching TIMEOUT the block SHALL drop bus_req, go to DONE, set load_data=0 (loads only), and pulse timeout_err=1 during DONE.
REQ-015 bus_ack SHALL be ignored in IDLE and DONE; bus_rdata SHALL be ignored except on the accepting edge.
REQ-016 Request inputs SHALL be sampled only in IDLE; changes during REQ SHALL NOT affect the transaction.

Reset
REQ-017 When rst_n=0 at a rising edge: state=IDLE, counter=0, load_data=0, latched registers=0; bus_req, bus_we, bus_wstrb, timeout_err SHALL read 0 the cycle after.
REQ-018 Reset during REQ SHALL abort the transaction with no DONE cycle; an ack in the reset cycle SHALL be ignored.

Verification
REQ-019 LB addr=0x103, bus_rdata=0x80FF_1234, ack first REQ cycle -> bus_addr=0x100, load_data=0xFFFF_FF80, stall high 2 cycles then low in DONE.
REQ-020 SH addr=0x22, store_data=0x0000_ABCD -> bus_wstrb=4'b1100, bus_wdata=0xABCD_ABCD, bus_we=1; LHU same addr, rdata=0xABCD_0000 -> load_data=0x0000_ABCD.
REQ-021 LW addr=0x06 -> misaligned=1, stall=0, bus_req never asserts, load_data unchanged.
REQ-022 TIMEOUT=4, LW, bus_ack held 0 -> bus_req high 4 cycles, then timeout_err=1 for 1 cycle, load_data=0, state IDLE.
REQ-023 rst_n=0 in 2nd REQ cycle of SW with bus_ack=1 -> bus_req=0 next cycle, no DONE, timeout_err=0, load_data=0.
REQ-024 Back-to-back LW(0x10) then SW(0x14), ack after 3 wait cycles each -> two separate transactions, stall low exactly one cycle between them.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns controller load/store requests into single-beat word-bus
// transactions with byte/halfword lane steering, sign extension and a bus timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  data_mem_mode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misaligned,
    output logic        timeout_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, next_state;
    logic [7:0]  wait_cnt;
    logic [31:0] lat_addr;
    logic [2:0]  lat_mode;
    logic        lat_we;
    logic [3:0]  lat_wstrb;
    logic [31:0] lat_wdata;
    logic        timed_out;

    logic        req_any;
    logic        is_byte;
    logic        is_half;
    logic        mis_cond;
    logic        start;
    logic        ack_ok;
    logic        tmo_hit;
    logic [3:0]  new_wstrb;
    logic [31:0] new_wdata;
    logic [31:0] rd_byte_sh;
    logic [31:0] rd_half_sh;
    logic [31:0] load_ext;

    assign req_any = mem_read | mem_write;

    // Unknown store codes behave as SW, unknown load codes as LW, which
    // is why the size decode differs by direction.
    always_comb begin
        if (mem_write) begin
            is_byte = (data_mem_mode == 3'b000);
            is_half = (data_mem_mode == 3'b001);
        end else begin
            is_byte = (data_mem_mode[1:0] == 2'b00);
            is_half = (data_mem_mode[1:0] == 2'b01);
        end
    end

    always_comb begin
        mis_cond = 1'b0;
        if (is_half)
            mis_cond = addr[0];
        else if (!is_byte)
            mis_cond = (addr[1:0] != 2'b00);
    end

    always_comb begin
        new_wstrb = '0;
        new_wdata = '0;
        if (mem_write) begin
            if (is_byte) begin
                new_wstrb = 4'b0001 << addr[1:0];
                new_wdata = {4{store_data[7:0]}};
            end else if (is_half) begin
                new_wstrb = 4'b0011 << {addr[1], 1'b0};
                new_wdata = {2{store_data[15:0]}};
            end else begin
                new_wstrb = 4'b1111;
                new_wdata = store_data;
            end
        end
    end

    assign start   = (state == IDLE) & req_any & ~mis_cond;
    assign ack_ok  = (state == REQ) & bus_ack;
    assign tmo_hit = (state == REQ) & ~bus_ack & (wait_cnt == TMO_LAST);

    assign rd_byte_sh = bus_rdata >> {lat_addr[1:0], 3'b000};
    assign rd_half_sh = bus_rdata >> {lat_addr[1], 4'b0000};

    always_comb begin
        case (lat_mode)
            3'b000:  load_ext = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
            3'b001:  load_ext = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
            3'b100:  load_ext = {24'h000000, rd_byte_sh[7:0]};
            3'b101:  load_ext = {16'h0000, rd_half_sh[15:0]};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = REQ;
            REQ:     if (ack_ok || tmo_hit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus_req     = (state == REQ);
        misaligned  = (state == IDLE) & req_any & mis_cond;
        stall       = req_any & (state != DONE) & ~misaligned;
        timeout_err = (state == DONE) & timed_out;
        bus_we      = lat_we;
        bus_addr    = {lat_addr[31:2], 2'b00};
        bus_wstrb   = lat_wstrb;
        bus_wdata   = lat_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_mode  <= '0;
            lat_we    <= 1'b0;
            lat_wstrb <= '0;
            lat_wdata <= '0;
            timed_out <= 1'b0;
            load_data <= '0;
        end else begin
            if (start) begin
                wait_cnt  <= '0;
                lat_addr  <= addr;
                lat_mode  <= data_mem_mode;
                lat_we    <= mem_write;
                lat_wstrb <= new_wstrb;
                lat_wdata <= new_wdata;
                timed_out <= 1'b0;
            end
            if (ack_ok) begin
                if (!lat_we)
                    load_data <= load_ext;
            end else if (state == REQ) begin
                wait_cnt <= wait_cnt + 8'd1;
                if (tmo_hit) begin
                    timed_out <= 1'b1;
                    if (!lat_we)
                        load_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios followed by random accesses,
// all checked against a transaction-level reference model.
module tb_load_store_unit;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  data_mem_mode;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        stall, misaligned, timeout_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] model_ld = '0;
    bit          in_done = 0;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .data_mem_mode(data_mem_mode), .addr(addr), .store_data(store_data),
        .load_data(load_data), .stall(stall), .misaligned(misaligned),
        .timeout_err(timeout_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes as the instruction set defines it
    function automatic int unsigned size_of(input bit wr, input logic [2:0] m);
        if (wr) return (m == 3'd0) ? 1 : (m == 3'd1) ? 2 : 4;
        if (m == 3'd0 || m == 3'd4) return 1;
        if (m == 3'd1 || m == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] m, input logic [31:0] a,
                                        input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> ((a % 4) * 8)) & 32'hFF;
        h = (w >> (((a % 4) / 2) * 16)) & 32'hFFFF;
        case (m)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic idle_cycles(input int unsigned n);
        mem_read = 0; mem_write = 0; bus_ack = 0;
        repeat (n) @(negedge clk);
        in_done = 0;
        chk("idle_no_req", bus_req, 0);
        chk("idle_no_tmo", timeout_err, 0);
        chk("idle_no_stall", stall, 0);
    endtask

    // One request; wait_n = REQ cycles without ack before the ack (>= TMO times out)
    task automatic access(input bit rd, input bit wr, input logic [2:0] mode,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rw, input int unsigned wait_n);
        int unsigned sz;
        logic [31:0] exp_strb, exp_wdata;
        bit timed;
        mem_read = rd; mem_write = wr; data_mem_mode = mode; addr = a;
        store_data = sd; bus_ack = 0; bus_rdata = $urandom;
        if (in_done) @(negedge clk);
        in_done = 0;
        #1;
        sz = size_of(wr, mode);
        if (a % sz != 0) begin
            chk("misaligned_flag", misaligned, 1);
            chk("misaligned_stall", stall, 0);
            @(negedge clk);
            chk("misaligned_no_req", bus_req, 0);
            chk("misaligned_load_hold", load_data, model_ld);
            mem_read = 0; mem_write = 0;
            return;
        end
        chk("aligned_flag", misaligned, 0);
        chk("idle_stall", stall, 1);
        exp_strb  = !wr ? 0 : (sz == 1) ? (1 << (a % 4)) : (sz == 2) ? (3 << (a % 4)) : 15;
        exp_wdata = (sz == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
                    (sz == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
        timed = 0;
        for (int unsigned k = 0; k < TMO; k++) begin
            @(negedge clk);
            chk("req_bus_req", bus_req, 1);
            chk("req_stall", stall, 1);
            chk("req_bus_we", bus_we, wr);
            chk("req_bus_addr", bus_addr, a & 32'hFFFF_FFFC);
            chk("req_bus_wstrb", bus_wstrb, exp_strb);
            if (wr) chk("req_bus_wdata", bus_wdata, exp_wdata);
            // Inputs are free to change once the transaction is latched
            addr = $urandom; store_data = $urandom; data_mem_mode = 3'($urandom);
            bus_rdata = $urandom;
            if (k == wait_n) begin
                bus_ack = 1; bus_rdata = rw;
                break;
            end
            if (k == TMO - 1) timed = 1;
        end
        if (!wr) model_ld = timed ? 32'h0 : ext(mode, a, rw);
        @(negedge clk);
        bus_ack = 0;
        chk("done_bus_req", bus_req, 0);
        chk("done_stall", stall, 0);
        chk("done_timeout", timeout_err, timed);
        chk("done_load_data", load_data, model_ld);
        in_done = 1;
    endtask

    initial begin
        rst_n = 0; mem_read = 0; mem_write = 0; data_mem_mode = 0; addr = 0;
        store_data = 0; bus_ack = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_load_data", load_data, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_stall", stall, 0);
        rst_n = 1;
        @(negedge clk);

        access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0);
        chk("lb_value", load_data, 32'hFFFF_FF80);
        idle_cycles(1);
        access(0, 1, 3'd1, 32'h22, 32'h0000_ABCD, 32'h0, 1);
        access(1, 0, 3'd5, 32'h22, 32'h0, 32'hABCD_0000, 0);
        chk("lhu_value", load_data, 32'h0000_ABCD);
        access(1, 0, 3'd2, 32'h06, 32'h0, 32'h1111_1111, 0);
        chk("misaligned_keeps", load_data, 32'h0000_ABCD);

        access(1, 0, 3'd2, 32'h10, 32'h0, 32'h1234_5678, 3);
        access(0, 1, 3'd2, 32'h14, 32'hCAFE_F00D, 32'h0, 3);
        chk("b2b_load_kept", load_data, 32'h1234_5678);
        idle_cycles(1);

        // Reset in the second REQ cycle of a store with ack high
        mem_write = 1; data_mem_mode = 3'd2; addr = 32'h40; store_data = 32'h5555_AAAA;
        @(negedge clk);
        chk("rstreq_req1", bus_req, 1);
        @(negedge clk);
        chk("rstreq_req2", bus_req, 1);
        rst_n = 0; bus_ack = 1; mem_write = 0;
        @(negedge clk);
        model_ld = 0;
        chk("rstreq_bus_req", bus_req, 0);
        chk("rstreq_timeout", timeout_err, 0);
        chk("rstreq_load_data", load_data, 0);
        chk("rstreq_bus_we", bus_we, 0);
        chk("rstreq_bus_wstrb", bus_wstrb, 0);
        rst_n = 1; bus_ack = 0;
        @(negedge clk);
        chk("rstreq_no_done", timeout_err, 0);
        chk("rstreq_idle_req", bus_req, 0);

        access(1, 0, 3'd2, 32'h20, 32'h0, 32'hDEAD_BEEF, 1);
        access(1, 0, 3'd2, 32'h24, 32'h0, 32'h0BAD_0BAD, 10);
        chk("timeout_zero", load_data, 0);
        idle_cycles(1);

        for (int unsigned i = 0; i < 120; i++) begin
            bit wr, rd;
            wr = 1'($urandom);
            rd = !wr || (($urandom % 4) == 0);
            access(rd, wr, 3'($urandom), $urandom, $urandom, $urandom, $urandom % 6);
            if (($urandom % 3) == 0) idle_cycles(1 + $urandom % 2);
        end
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
